pipeline_hazard_sequencer: RTL and testbench

//  Central stall/flush sequencer for the 5-stage OTTER pipeline (IF/ID/EX/MEM/WB).
//  - Collects hazard requests from the ID-stage forwarding units, the EX branch unit and data memory.
//  - Drives the write-enable and flush (bubble) controls of every pipeline register and the PC.
//  - Counts multi-cycle JALR load stalls internally and keeps stall/flush performance counters.

---
 rtl/otter_hazard_pkg.sv | 13 +
 rtl/hazard_perf_cnt.sv | 26 ++
 rtl/pipeline_hazard_sequencer.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/otter_hazard_pkg.sv
// Shared types and constants for the OTTER pipeline hazard sequencer.
package otter_hazard_pkg;

   typedef enum logic [1:0] {
      HZ_RUN    = 2'b00,
      HZ_JSTALL = 2'b01,
      HZ_MWAIT  = 2'b10
   } hz_state_t;

   localparam logic [1:0] STG_EX  = 2'b01;
   localparam logic [1:0] STG_MEM = 2'b10;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running event counter with synchronous active-low clear; wraps silently.
module hazard_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc) count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage OTTER pipeline: arbitrates hazard
// requests into pipeline-register enables/flushes and counts stall/flush cycles.
module pipeline_hazard_sequencer
   import otter_hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             mem_busy,
   input  logic             br_taken,
   input  logic             ld_use_req,
   input  logic             jalr_ld_req,
   input  logic [1:0]       jalr_ld_stg,
   input  logic             id_jump,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_we,
   output logic             id_ex_flush,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hz_state_t  st_q,  st_d;
   hz_state_t  ret_q, ret_d;
   hz_state_t  eff_st;
   logic [1:0] jcnt_q, jcnt_d;

   // Next state and control decode; outputs are combinational by design.
   always_comb begin
      st_d        = st_q;
      ret_d       = ret_q;
      jcnt_d      = jcnt_q;
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_we    = 1'b1;
      id_ex_flush = 1'b0;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
      eff_st      = (st_q == HZ_MWAIT) ? ret_q : st_q;

      if (!RST_N) begin
         pc_we       = 1'b0;
         if_id_we    = 1'b0;
         id_ex_we    = 1'b0;
         ex_mem_we   = 1'b0;
         mem_wb_we   = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         st_d        = HZ_RUN;
         ret_d       = HZ_RUN;
         jcnt_d      = 2'd0;
      end else if (mem_busy) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         mem_wb_we = 1'b0;
         st_d      = HZ_MWAIT;
         if (st_q != HZ_MWAIT) ret_d = st_q;
      end else begin
         st_d = eff_st;
         if (br_taken) begin
            // Squashes any stalled JALR along with the wrong path.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            st_d        = HZ_RUN;
            jcnt_d      = 2'd0;
         end else if (eff_st == HZ_JSTALL && jcnt_q != 2'd0) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
            jcnt_d      = jcnt_q - 2'd1;
         end else if (eff_st == HZ_JSTALL) begin
            // Stall complete: behave as RUN, but the re-asserting stall sources are ignored.
            st_d = HZ_RUN;
            if (id_jump) if_id_flush = 1'b1;
         end else if (jalr_ld_req) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
            st_d        = HZ_JSTALL;
            jcnt_d      = (jalr_ld_stg == STG_MEM) ? 2'd0 : 2'd1;
         end else if (ld_use_req) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
         end else if (id_jump) begin
            if_id_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      st_q   <= st_d;
      ret_q  <= ret_d;
      jcnt_q <= jcnt_d;
   end

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RST_N (RST_N),
      .inc   (RST_N & ~pc_we),
      .count (stall_cnt)
   );

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .RST_N (RST_N),
      .inc   (RST_N & if_id_flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed self-checking bench for pipeline_hazard_sequencer (CNT_W=4 build).
module tb_pipeline_hazard_sequencer;

   localparam int unsigned CNT_W = 4;

   // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we}
   localparam logic [6:0] C_RST   = 7'b0010100;
   localparam logic [6:0] C_RUN   = 7'b1101011;
   localparam logic [6:0] C_STALL = 7'b0001111;
   localparam logic [6:0] C_JUMP  = 7'b1111011;
   localparam logic [6:0] C_BR    = 7'b1111111;
   localparam logic [6:0] C_FRZ   = 7'b0000000;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             mem_busy, br_taken, ld_use_req, jalr_ld_req, id_jump;
   logic [1:0]       jalr_ld_stg;
   logic             pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [6:0]       ctl;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   assign ctl = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we};

   pipeline_hazard_sequencer #(.CNT_W(CNT_W)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .mem_busy    (mem_busy),
      .br_taken    (br_taken),
      .ld_use_req  (ld_use_req),
      .jalr_ld_req (jalr_ld_req),
      .jalr_ld_stg (jalr_ld_stg),
      .id_jump     (id_jump),
      .pc_we       (pc_we),
      .if_id_we    (if_id_we),
      .if_id_flush (if_id_flush),
      .id_ex_we    (id_ex_we),
      .id_ex_flush (id_ex_flush),
      .ex_mem_we   (ex_mem_we),
      .mem_wb_we   (mem_wb_we),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_in();
      mem_busy    = 1'b0;
      br_taken    = 1'b0;
      ld_use_req  = 1'b0;
      jalr_ld_req = 1'b0;
      jalr_ld_stg = 2'b01;
      id_jump     = 1'b0;
   endtask

   task automatic do_reset();
      clear_in();
      RST_N = 1'b0;
      tick();
      tick();
      RST_N = 1'b1;
      #1;
   endtask

   initial begin
      clear_in();
      RST_N = 1'b0;

      // 1: reset held three cycles, then release
      tick(); tick(); tick();
      check("rst_ctl", 32'(ctl), 32'(C_RST));
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      RST_N = 1'b1;
      #1;
      check("run_ctl", 32'(ctl), 32'(C_RUN));

      // 2: single-cycle load-use stall
      ld_use_req = 1'b1;
      #1 check("lu_ctl", 32'(ctl), 32'(C_STALL));
      tick();
      ld_use_req = 1'b0;
      #1 check("lu_after", 32'(ctl), 32'(C_RUN));
      check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

      // 3a: JALR waiting on a load in EX -> two bubbles, then jump honoured
      do_reset();
      jalr_ld_req = 1'b1; jalr_ld_stg = 2'b01;
      #1 check("jex_s1", 32'(ctl), 32'(C_STALL));
      tick();
      #1 check("jex_s2", 32'(ctl), 32'(C_STALL));
      tick();
      #1 check("jex_done", 32'(ctl), 32'(C_RUN));
      jalr_ld_req = 1'b0; id_jump = 1'b1;
      #1 check("jex_jump", 32'(ctl), 32'(C_JUMP));
      tick();
      id_jump = 1'b0;
      #1 check("jex_after", 32'(ctl), 32'(C_RUN));
      check("jex_stall_cnt", 32'(stall_cnt), 32'd2);
      check("jex_flush_cnt", 32'(flush_cnt), 32'd1);

      // 3b: JALR waiting on a load in MEM -> one bubble
      do_reset();
      jalr_ld_req = 1'b1; jalr_ld_stg = 2'b10;
      #1 check("jmem_s1", 32'(ctl), 32'(C_STALL));
      tick();
      #1 check("jmem_done", 32'(ctl), 32'(C_RUN));
      jalr_ld_req = 1'b0;
      tick();
      check("jmem_stall_cnt", 32'(stall_cnt), 32'd1);

      // 4: branch mispredict aborts a JALR stall
      do_reset();
      jalr_ld_req = 1'b1; jalr_ld_stg = 2'b01;
      tick();
      br_taken = 1'b1;
      #1 check("br_ctl", 32'(ctl), 32'(C_BR));
      tick();
      br_taken = 1'b0; jalr_ld_req = 1'b0;
      #1 check("br_after1", 32'(ctl), 32'(C_RUN));
      tick();
      check("br_after2", 32'(ctl), 32'(C_RUN));
      check("br_stall_cnt", 32'(stall_cnt), 32'd1);
      check("br_flush_cnt", 32'(flush_cnt), 32'd1);

      // 5: memory freeze in the middle of a JALR stall
      do_reset();
      jalr_ld_req = 1'b1; jalr_ld_stg = 2'b01;
      tick();
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check($sformatf("mw_frz%0d", i), 32'(ctl), 32'(C_FRZ));
         tick();
      end
      mem_busy = 1'b0;
      #1 check("mw_resume", 32'(ctl), 32'(C_STALL));
      tick();
      #1 check("mw_done", 32'(ctl), 32'(C_RUN));
      jalr_ld_req = 1'b0;
      tick();
      check("mw_stall_cnt", 32'(stall_cnt), 32'd6);
      check("mw_flush_cnt", 32'(flush_cnt), 32'd0);

      // 6: counter wrap; load-use beats a simultaneous ID jump
      do_reset();
      ld_use_req = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      check("wrap_pre", 32'(stall_cnt), 32'd15);
      id_jump = 1'b1;
      #1 check("wrap_ctl", 32'(ctl), 32'(C_STALL));
      tick();
      clear_in();
      #1 check("wrap_stall_cnt", 32'(stall_cnt), 32'd0);
      check("wrap_flush_cnt", 32'(flush_cnt), 32'd0);

      // Reset asserted mid-run clears counters and forces reset controls
      RST_N = 1'b0;
      #1 check("rst2_ctl", 32'(ctl), 32'(C_RST));
      tick();
      check("rst2_stall_cnt", 32'(stall_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
